io_accum_port: RTL and testbench



---
 rtl/io_accum_port.sv | 220 ++++++++++++++++++++++
 tb/tb_io_accum_port.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_accum_port.sv
// -----------------------------------------------------------------------------
// io_accum_port
//
// User-project I/O engine sitting between the GPIO pads and user-area logic.
// Raw pad inputs and a strobe pad are synchronised, strobe rising edges are
// detected, and an OUT_W-bit result register is updated in one of four modes:
//   00 COUNT  : +1 per strobe event
//   01 ACCUM  : + synced in_pins (zero-extended / truncated to OUT_W) per event
//   10 FREE   : +1 every cycle while running, events ignored
//   11 LOAD   : result = synced in_pins (low OUT_W bits) per event
// The result drives the output pads; pads are tristated while idle. A sticky
// done flag marks that the result reached TARGET, and a sticky overflow flag
// marks a carry out of the OUT_W-bit adder.
//
// Ports
//   clock      : single clock, rising edge
//   resetb     : asynchronous active-low reset
//   in_pins    : raw pad inputs (asynchronous), IN_W bits
//   strobe_pin : raw pad strobe (asynchronous), rising edge = event
//   mode       : update mode (see above), quasi-static
//   enable     : synchronous run enable
//   clear      : synchronous clear of result, done, overflow
//   out_val    : result register, to output pads
//   out_oeb    : pad output enable, active low
//   done       : sticky, result equalled TARGET
//   overflow   : sticky, an update carried out of OUT_W bits
// -----------------------------------------------------------------------------
module io_accum_port #(
  parameter int OUT_W          = 5,  // result width / output pad count (2..16)
  parameter int IN_W           = 6,  // input pad count (1..16)
  parameter int SYNC_STAGES    = 2,  // synchroniser depth (2..3)
  parameter int TARGET         = 7,  // value that sets done; must fit OUT_W bits
  parameter int SATURATE       = 0,  // 1 = clamp at all-ones, 0 = wrap
  parameter int STOP_ON_TARGET = 1   // 1 = freeze result once TARGET is reached
) (
  input  logic             clock,
  input  logic             resetb,
  input  logic [IN_W-1:0]  in_pins,
  input  logic             strobe_pin,
  input  logic [1:0]       mode,
  input  logic             enable,
  input  logic             clear,
  output logic [OUT_W-1:0] out_val,
  output logic [OUT_W-1:0] out_oeb,
  output logic             done,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_COUNT = 2'b00,
    M_ACCUM = 2'b01,
    M_FREE  = 2'b10,
    M_LOAD  = 2'b11
  } mode_t;

  localparam logic [OUT_W-1:0] TARGET_V = OUT_W'(TARGET);
  localparam logic [OUT_W-1:0] ALL_ONES = '1;
  localparam logic [OUT_W-1:0] ONE      = OUT_W'(1);

  // ---------------------------------------------------------------------------
  // Synchronisers and strobe edge detector
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][IN_W-1:0] r_in_sync;
  logic [SYNC_STAGES-1:0]           r_strb_sync;
  logic                             r_strb_prev;

  // NOTE: every flop here, synchroniser chain included, sits on the async reset
  // so the edge detector cannot see a phantom rising edge after reset release.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_in_sync   <= '0;
      r_strb_sync <= '0;
      r_strb_prev <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage capture the previous
      // stage's old value, giving a true shift register rather than a wire.
      r_in_sync   <= {r_in_sync[SYNC_STAGES-2:0], in_pins};
      r_strb_sync <= {r_strb_sync[SYNC_STAGES-2:0], strobe_pin};
      r_strb_prev <= r_strb_sync[SYNC_STAGES-1];
    end
  end

  logic [IN_W-1:0]  w_in_sync;
  logic [OUT_W-1:0] w_in_fit;
  logic             w_ev;

  assign w_in_sync = r_in_sync[SYNC_STAGES-1];
  // Size cast zero-extends when IN_W < OUT_W and keeps the low bits otherwise.
  assign w_in_fit  = OUT_W'(w_in_sync);
  // One-cycle pulse per synchronised rising edge; a held-high strobe never
  // re-triggers, so short or long pulses can't double-count.
  assign w_ev      = r_strb_sync[SYNC_STAGES-1] & ~r_strb_prev;

  // ---------------------------------------------------------------------------
  // Update datapath
  // ---------------------------------------------------------------------------
  logic [OUT_W-1:0] r_result;
  logic [OUT_W-1:0] w_addend;
  logic             w_do_add;
  logic             w_do_load;
  logic [OUT_W:0]   w_sum;
  logic             w_carry;
  logic [OUT_W-1:0] w_sum_fit;

  // NOTE: every signal gets a default at the top of the block so no path
  // through the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_addend  = '0;
    w_do_add  = 1'b0;
    w_do_load = 1'b0;
    case (mode_t'(mode))
      M_COUNT: begin
        w_addend = ONE;
        w_do_add = w_ev;
      end
      M_ACCUM: begin
        w_addend = w_in_fit;
        w_do_add = w_ev;
      end
      M_FREE: begin
        w_addend = ONE;
        w_do_add = 1'b1;
      end
      M_LOAD: begin
        w_do_load = w_ev;
      end
      default: begin
        w_do_add  = 1'b0;
        w_do_load = 1'b0;
      end
    endcase

    // One extra bit captures the carry that drives overflow.
    w_sum     = {1'b0, r_result} + {1'b0, w_addend};
    w_carry   = w_sum[OUT_W];
    w_sum_fit = (w_carry && (SATURATE != 0)) ? ALL_ONES : w_sum[OUT_W-1:0];
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [OUT_W-1:0] r_oeb;
  logic             r_done;
  logic             r_ovf;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_oeb    <= '1;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (clear) begin
      // Clear wins over any update; only HOLD changes state, so a frozen
      // result can be restarted from zero without toggling enable.
      r_result <= '0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      if (r_state == ST_HOLD) begin
        r_state <= ST_RUN;
      end
    end else begin
      // done looks at the registered result, so it rises one edge after the
      // result reaches TARGET, whatever the state.
      if (r_result == TARGET_V) begin
        r_done <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          // Events arriving here are dropped; the edge detector keeps running
          // so nothing is pending when RUN is entered.
          if (enable) begin
            r_state <= ST_RUN;
            r_oeb   <= '0;
          end
        end
        ST_RUN: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_oeb   <= '1;
          end else if ((r_result == TARGET_V) && (STOP_ON_TARGET != 0)) begin
            // Freeze lands on the same edge that raises done.
            r_state <= ST_HOLD;
          end else if (w_do_load) begin
            r_result <= w_in_fit;
          end else if (w_do_add) begin
            r_result <= w_sum_fit;
            if (w_carry) begin
              r_ovf <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (!enable) begin
            r_state <= ST_IDLE;
            r_oeb   <= '1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_oeb   <= '1;
        end
      endcase
    end
  end

  assign out_val  = r_result;
  assign out_oeb  = r_oeb;
  assign done     = r_done;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_io_accum_port.sv
// -----------------------------------------------------------------------------
// tb_io_accum_port
//
// Directed bench for io_accum_port. Three instances share one set of inputs:
//   dut_a : defaults (STOP_ON_TARGET=1, SATURATE=0)
//   dut_b : STOP_ON_TARGET=0, SATURATE=0
//   dut_c : STOP_ON_TARGET=0, SATURATE=1
// Inputs change just after the falling edge; outputs are sampled at falling
// edges (or 1 time unit after one for the asynchronous reset check).
// -----------------------------------------------------------------------------
module tb_io_accum_port;

  logic       clock;
  logic       resetb;
  logic [5:0] in_pins;
  logic       strobe_pin;
  logic [1:0] mode;
  logic       enable;
  logic       clear;

  logic [4:0] a_val, a_oeb, b_val, b_oeb, c_val, c_oeb;
  logic       a_done, a_ovf, b_done, b_ovf, c_done, c_ovf;

  int total = 0;
  int bad   = 0;

  io_accum_port dut_a (
    .clock(clock), .resetb(resetb), .in_pins(in_pins), .strobe_pin(strobe_pin),
    .mode(mode), .enable(enable), .clear(clear),
    .out_val(a_val), .out_oeb(a_oeb), .done(a_done), .overflow(a_ovf)
  );

  io_accum_port #(.STOP_ON_TARGET(0), .SATURATE(0)) dut_b (
    .clock(clock), .resetb(resetb), .in_pins(in_pins), .strobe_pin(strobe_pin),
    .mode(mode), .enable(enable), .clear(clear),
    .out_val(b_val), .out_oeb(b_oeb), .done(b_done), .overflow(b_ovf)
  );

  io_accum_port #(.STOP_ON_TARGET(0), .SATURATE(1)) dut_c (
    .clock(clock), .resetb(resetb), .in_pins(in_pins), .strobe_pin(strobe_pin),
    .mode(mode), .enable(enable), .clear(clear),
    .out_val(c_val), .out_oeb(c_oeb), .done(c_done), .overflow(c_ovf)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Strobe high 4 cycles, low 4 cycles; the update lands inside the high phase.
  task automatic pulse();
    strobe_pin = 1'b1;
    tick(4);
    strobe_pin = 1'b0;
    tick(4);
  endtask

  task automatic test_reset();
    tick(2);
    total++;
    if ({a_val, a_oeb, a_done, a_ovf} !== {5'h00, 5'h1F, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_a: got %h want %h", {a_val, a_oeb, a_done, a_ovf}, {5'h00, 5'h1F, 1'b0, 1'b0});
    end
    total++;
    if ({b_val, b_oeb, b_done, b_ovf} !== {5'h00, 5'h1F, 1'b0, 1'b0}) begin
      bad++; $display("FAIL reset_b: got %h want %h", {b_val, b_oeb, b_done, b_ovf}, {5'h00, 5'h1F, 1'b0, 1'b0});
    end
    resetb = 1'b1;
    tick(2);
    total++;
    if (a_oeb !== 5'h1F) begin
      bad++; $display("FAIL idle_oeb: got %h want 1f", a_oeb);
    end
  endtask

  task automatic test_count();
    logic [4:0] exp_a;
    mode   = 2'b00;
    enable = 1'b1;
    tick(1);
    total++;
    if (a_oeb !== 5'h00) begin
      bad++; $display("FAIL enable_oeb: got %h want 00", a_oeb);
    end
    for (int i = 1; i <= 9; i++) begin
      strobe_pin = 1'b1;
      tick(3);
      exp_a = (i > 7) ? 5'd7 : 5'(i);
      total++;
      if (a_val !== exp_a) begin
        bad++; $display("FAIL count_a[%0d]: got %0d want %0d", i, a_val, exp_a);
      end
      total++;
      if (b_val !== 5'(i)) begin
        bad++; $display("FAIL count_b[%0d]: got %0d want %0d", i, b_val, i);
      end
      if (i == 7) begin
        total++;
        if (a_done !== 1'b0) begin
          bad++; $display("FAIL done_early: got %b want 0", a_done);
        end
      end
      tick(1);
      if (i == 7) begin
        total++;
        if (a_done !== 1'b1) begin
          bad++; $display("FAIL done_rise: got %b want 1", a_done);
        end
      end
      strobe_pin = 1'b0;
      tick(4);
    end
    total++;
    if ({b_done, c_val, a_oeb} !== {1'b1, 5'd9, 5'h00}) begin
      bad++; $display("FAIL count_end: got %h want %h", {b_done, c_val, a_oeb}, {1'b1, 5'd9, 5'h00});
    end
  endtask

  task automatic test_accum();
    in_pins = 6'h23;
    mode    = 2'b01;
    clear   = 1'b1;
    tick(1);
    clear = 1'b0;
    total++;
    if ({a_val, a_done, a_ovf} !== 7'b0) begin
      bad++; $display("FAIL clear_hold: got %h want 00", {a_val, a_done, a_ovf});
    end
    tick(3);
    for (int i = 1; i <= 3; i++) begin
      pulse();
      total++;
      if (b_val !== 5'(3 * i)) begin
        bad++; $display("FAIL accum_b[%0d]: got %0d want %0d", i, b_val, 3 * i);
      end
    end
    total++;
    if ({b_done, b_ovf} !== 2'b00) begin
      bad++; $display("FAIL accum_flags: got %b want 00", {b_done, b_ovf});
    end
  endtask

  task automatic test_overflow();
    in_pins = 6'h1F;
    clear   = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(3);
    pulse();
    total++;
    if ({b_val, b_ovf, c_val, c_ovf} !== {5'd31, 1'b0, 5'd31, 1'b0}) begin
      bad++; $display("FAIL ovf_first: got %h want %h", {b_val, b_ovf, c_val, c_ovf}, {5'd31, 1'b0, 5'd31, 1'b0});
    end
    pulse();
    total++;
    if ({b_val, b_ovf} !== {5'd30, 1'b1}) begin
      bad++; $display("FAIL ovf_wrap: got val=%0d ovf=%b want val=30 ovf=1", b_val, b_ovf);
    end
    total++;
    if ({c_val, c_ovf} !== {5'd31, 1'b1}) begin
      bad++; $display("FAIL ovf_sat: got val=%0d ovf=%b want val=31 ovf=1", c_val, c_ovf);
    end
  endtask

  task automatic test_free();
    mode  = 2'b10;
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    total++;
    if (b_val !== 5'd0) begin
      bad++; $display("FAIL free_start: got %0d want 0", b_val);
    end
    for (int i = 1; i <= 40; i++) begin
      tick(1);
      total++;
      if (b_val !== 5'(i)) begin
        bad++; $display("FAIL free_b[%0d]: got %0d want %0d", i, b_val, i % 32);
      end
      if (i == 7 || i == 8 || i == 40) begin
        total++;
        if (b_done !== (i != 7)) begin
          bad++; $display("FAIL free_done[%0d]: got %b want %b", i, b_done, (i != 7));
        end
      end
      if (i == 31 || i == 32) begin
        total++;
        if (b_ovf !== (i == 32)) begin
          bad++; $display("FAIL free_ovf[%0d]: got %b want %b", i, b_ovf, (i == 32));
        end
      end
    end
    total++;
    if ({a_val, a_done, c_val, c_ovf} !== {5'd7, 1'b1, 5'd31, 1'b1}) begin
      bad++; $display("FAIL free_hold_sat: got %h want %h", {a_val, a_done, c_val, c_ovf}, {5'd7, 1'b1, 5'd31, 1'b1});
    end
    enable = 1'b0;
    tick(1);
    total++;
    if ({b_oeb, b_val} !== {5'h1F, 5'd8}) begin
      bad++; $display("FAIL free_stop: got oeb=%h val=%0d want oeb=1f val=8", b_oeb, b_val);
    end
    tick(3);
    total++;
    if ({b_val, a_oeb} !== {5'd8, 5'h1F}) begin
      bad++; $display("FAIL free_idle: got %h want %h", {b_val, a_oeb}, {5'd8, 5'h1F});
    end
  endtask

  task automatic test_load();
    in_pins = 6'h2B;
    mode    = 2'b11;
    clear   = 1'b1;
    tick(1);
    clear  = 1'b0;
    enable = 1'b1;
    tick(3);
    strobe_pin = 1'b1;
    tick(2);
    total++;
    if (b_val !== 5'd0) begin
      bad++; $display("FAIL load_latency: got %h want 00", b_val);
    end
    tick(1);
    total++;
    if (b_val !== 5'h0B) begin
      bad++; $display("FAIL load_val: got %h want 0b", b_val);
    end
    tick(1);
    strobe_pin = 1'b0;
    tick(4);
    total++;
    if ({b_ovf, b_done} !== 2'b00) begin
      bad++; $display("FAIL load_flags: got %b want 00", {b_ovf, b_done});
    end
    in_pins = 6'h07;
    tick(3);
    pulse();
    total++;
    if ({b_val, b_done} !== {5'd7, 1'b1}) begin
      bad++; $display("FAIL load_target: got val=%0d done=%b want val=7 done=1", b_val, b_done);
    end
    // Clear lands on the same edge as the event: clear must win.
    in_pins = 6'h2B;
    tick(3);
    strobe_pin = 1'b1;
    tick(2);
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    total++;
    if ({b_val, b_done} !== {5'd0, 1'b0}) begin
      bad++; $display("FAIL clear_vs_ev: got val=%h done=%b want val=00 done=0", b_val, b_done);
    end
    tick(1);
    strobe_pin = 1'b0;
    tick(4);
    total++;
    if (b_val !== 5'd0) begin
      bad++; $display("FAIL clear_no_replay: got %h want 00", b_val);
    end
  endtask

  task automatic test_reset_mid();
    mode    = 2'b01;
    in_pins = 6'h23;
    clear   = 1'b1;
    tick(1);
    clear = 1'b0;
    tick(3);
    pulse();
    total++;
    if ({b_val, b_oeb} !== {5'd3, 5'h00}) begin
      bad++; $display("FAIL pre_reset: got %h want %h", {b_val, b_oeb}, {5'd3, 5'h00});
    end
    resetb = 1'b0;
    enable = 1'b0;
    #1;
    total++;
    if ({b_val, b_oeb, b_done, b_ovf} !== {5'h00, 5'h1F, 1'b0, 1'b0}) begin
      bad++; $display("FAIL async_reset: got %h want %h", {b_val, b_oeb, b_done, b_ovf}, {5'h00, 5'h1F, 1'b0, 1'b0});
    end
    total++;
    if ({a_val, a_oeb, a_done, a_ovf} !== {5'h00, 5'h1F, 1'b0, 1'b0}) begin
      bad++; $display("FAIL async_reset_a: got %h want %h", {a_val, a_oeb, a_done, a_ovf}, {5'h00, 5'h1F, 1'b0, 1'b0});
    end
    tick(1);
    resetb = 1'b1;
    tick(1);
    pulse();
    total++;
    if ({b_val, b_oeb} !== {5'd0, 5'h1F}) begin
      bad++; $display("FAIL idle_event: got %h want %h", {b_val, b_oeb}, {5'd0, 5'h1F});
    end
    enable = 1'b1;
    tick(2);
    total++;
    if ({b_val, b_oeb} !== {5'd0, 5'h00}) begin
      bad++; $display("FAIL no_queue: got %h want %h", {b_val, b_oeb}, {5'd0, 5'h00});
    end
    pulse();
    total++;
    if (b_val !== 5'd3) begin
      bad++; $display("FAIL post_reset_accum: got %0d want 3", b_val);
    end
  endtask

  initial begin
    resetb     = 1'b0;
    in_pins    = 6'h00;
    strobe_pin = 1'b0;
    mode       = 2'b00;
    enable     = 1'b0;
    clear      = 1'b0;

    test_reset();
    test_count();
    test_accum();
    test_overflow();
    test_free();
    test_load();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
